lcd_hd44780_driver: RTL

- Responder side of the `lcd_enable`/`lcd_bus`/`busy` character-LCD interface used by the menu/state controllers.
- After reset, runs the HD44780 8-bit power-on initialisation.
- Then accepts one 10-bit request per handshake and drives the panel pins (`rs`, `rw`, `en`, `lcd_data`) with the required setup, enable-pulse, hold and execution timing.
- Sits between the main controller and the board LCD header.

---
 rtl/lcd_hd44780_driver_if.sv | 13 +
 rtl/lcd_hd44780_driver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_driver_if.sv
// Request handshake between a menu/state controller (master) and the
// HD44780 panel driver (slave).
//   lcd_enable : request strobe, only looked at while busy is low
//   lcd_bus    : [10]=rs, [9]=rw (not supported, ignored), [8:1]=byte
//   busy       : driver is initialising or executing a request
interface lcd_hd44780_driver_if;
   logic        lcd_enable;
   logic [10:1] lcd_bus;
   logic        busy;

   modport master (output lcd_enable, output lcd_bus, input busy);
   modport slave  (input lcd_enable, input lcd_bus, output busy);
endinterface

// File: rtl/lcd_hd44780_driver.sv
// HD44780 8-bit character LCD driver.
// After reset it waits for the panel to power up, runs the four-command
// init sequence (0x38, 0x0C, 0x01, 0x06), then executes one request per
// handshake with setup / enable-pulse / hold / execution timing.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   bus       : request handshake (slave side)
//   rw        : panel R/W, always write
//   rs, en    : panel register select and enable strobe
//   lcd_data  : panel DB7..DB0
//
// state    | meaning
// ---------+--------------------------------------------------------
// POWER_UP | wait for panel power-up before the first init command
// SETUP    | rs/data presented, en low
// PULSE    | en high
// HOLD     | en low, rs/data still held
// EXEC     | panel executing; short or long wait depending on command
// READY    | idle, busy low, accepting requests
module lcd_hd44780_driver #(
   parameter int unsigned CLK_FREQ     = 50,
   parameter int unsigned T_POWERUP_US = 50000,
   parameter int unsigned T_EN_US      = 1,
   parameter int unsigned T_SHORT_US   = 50,
   parameter int unsigned T_LONG_US    = 2000
) (
   input  logic                        clk,
   input  logic                        rst,
   lcd_hd44780_driver_if.slave         bus,
   output logic                        rw,
   output logic                        rs,
   output logic                        en,
   output logic [7:0]                  lcd_data
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned P_CYC   = T_POWERUP_US * CLK_FREQ;
   localparam int unsigned S_CYC   = T_EN_US * CLK_FREQ;
   localparam int unsigned SH_CYC  = T_SHORT_US * CLK_FREQ;
   localparam int unsigned LG_CYC  = T_LONG_US * CLK_FREQ;
   localparam int unsigned MAX_CYC = max2(max2(P_CYC, LG_CYC), max2(SH_CYC, S_CYC));
   localparam int          CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

   // Terminal counts: a phase of N cycles ends when the counter reaches N-1.
   localparam logic [CNT_W-1:0] P_TC  = CNT_W'(P_CYC - 1);
   localparam logic [CNT_W-1:0] S_TC  = CNT_W'(S_CYC - 1);
   localparam logic [CNT_W-1:0] SH_TC = CNT_W'(SH_CYC - 1);
   localparam logic [CNT_W-1:0] LG_TC = CNT_W'(LG_CYC - 1);

   typedef enum logic [2:0] {
      POWER_UP, SETUP, PULSE, HOLD, EXEC, READY
   } state_t;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;  // 8-bit bus, 2 lines, 5x8 font
         2'd1:    return 8'h0C;  // display on, cursor off
         2'd2:    return 8'h01;  // clear
         default: return 8'h06;  // entry mode: increment, no shift
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             en_q, en_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic [1:0]       idx_q, idx_d;
   logic             init_q, init_d;
   logic             long_wait;
   logic [CNT_W-1:0] exec_tc;
   logic             rw_req_unused;

   assign rw_req_unused = bus.lcd_bus[9];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= POWER_UP;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
         en_q    <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         idx_q   <= 2'd0;
         init_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         en_q    <= en_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         init_q  <= init_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      busy_d    = busy_q;
      en_d      = en_q;
      rs_d      = rs_q;
      data_d    = data_q;
      idx_d     = idx_q;
      init_d    = init_q;
      // Clear and return-home (0x01..0x03 on the command register) are slow.
      long_wait = !rs_q && (data_q inside {8'h01, 8'h02, 8'h03});
      exec_tc   = long_wait ? LG_TC : SH_TC;

      case (state_q)
         POWER_UP: begin
            if (cnt_q == P_TC) begin
               state_d = SETUP;
               cnt_d   = '0;
               rs_d    = 1'b0;
               data_d  = init_cmd(2'd0);
               idx_d   = 2'd0;
            end
         end
         SETUP: begin
            if (cnt_q == S_TC) begin
               state_d = PULSE;
               cnt_d   = '0;
               en_d    = 1'b1;
            end
         end
         PULSE: begin
            if (cnt_q == S_TC) begin
               state_d = HOLD;
               cnt_d   = '0;
               en_d    = 1'b0;
            end
         end
         HOLD: begin
            if (cnt_q == S_TC) begin
               state_d = EXEC;
               cnt_d   = '0;
            end
         end
         EXEC: begin
            if (cnt_q == exec_tc) begin
               cnt_d = '0;
               if (init_q && (idx_q != 2'd3)) begin
                  state_d = SETUP;
                  idx_d   = idx_q + 2'd1;
                  rs_d    = 1'b0;
                  data_d  = init_cmd(idx_q + 2'd1);
               end else begin
                  state_d = READY;
                  busy_d  = 1'b0;
                  init_d  = 1'b0;
               end
            end
         end
         READY: begin
            cnt_d = '0;
            if (bus.lcd_enable) begin
               state_d = SETUP;
               busy_d  = 1'b1;
               rs_d    = bus.lcd_bus[10];
               data_d  = bus.lcd_bus[8:1];
            end
         end
         default: begin
            state_d = POWER_UP;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.busy = busy_q;
   assign rw       = 1'b0;
   assign rs       = rs_q;
   assign en       = en_q;
   assign lcd_data = data_q;

endmodule
